// File: rtl/ppg_led_scheduler.sv
// ---------------------------------------------------------------------------
// ppg_led_scheduler
//
// Purpose:
//   Sequences one photoplethysmography frame at a time:
//     AMB (dark) -> IR_SET -> IR_SMP -> GAP (dark) -> RED_SET -> RED_SMP -> AMB
//   While an LED phase is active, this block drives that LED, the DC
//   compensation DAC code and the PGA gain for the phase. It averages
//   2^AVG_LOG2 ADC samples at the end of each LED phase and offers the
//   result on a valid/ready port.
//
// Optional feature (compile-time macro PPG_AMBIENT_SUB_EN):
//   When defined, the last N cycles of AMB are averaged too. Each IR/RED
//   result of the frame becomes (led_avg - amb_avg), saturated at 0.
//   When undefined, AMB is plain dark time and no ambient accumulator exists.
//
// Parameters:
//   SETTLE_CYC  cycles an LED is on before sampling (>=1)
//   DARK_CYC    cycles of each dark phase (>= 2^AVG_LOG2)
//   AVG_LOG2    log2 of samples averaged per phase (0..4)
//
// Ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   start, stop          begin sequencing / end at the next frame boundary
//   dc_ir, dc_red        DC compensation codes, latched on entry to AMB
//   pga_ir, pga_red      PGA gain codes, latched on entry to AMB
//   adc                  ADC result, valid every cycle
//   led_ir, led_red      LED drives (never both high)
//   dc_comp, pga_gain    analog front-end codes for the current phase
//   sample, sample_ch    averaged result and its channel (0=IR, 1=RED)
//   sample_valid/ready   result handshake
//   busy                 high in any state except IDLE
//   overrun              sticky: a result was dropped under backpressure
//
// Result handshake: sample/sample_ch are held stable while sample_valid=1.
// A transfer occurs on a rising clk edge with sample_valid=1 and
// sample_ready=1. A new result that arrives while the output holds an
// untransferred one is loaded if sample_ready=1 in that cycle. Otherwise,
// it is dropped and overrun is set.
// ---------------------------------------------------------------------------
module ppg_led_scheduler #(
  parameter int SETTLE_CYC = 16,
  parameter int DARK_CYC   = 8,
  parameter int AVG_LOG2   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [6:0] dc_ir,
  input  logic [6:0] dc_red,
  input  logic [3:0] pga_ir,
  input  logic [3:0] pga_red,
  input  logic [7:0] adc,
  output logic       led_ir,
  output logic       led_red,
  output logic [6:0] dc_comp,
  output logic [3:0] pga_gain,
  output logic [7:0] sample,
  output logic       sample_ch,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       busy,
  output logic       overrun
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = 16;

  // Counter reload values: each state counts down to 0 and then leaves.
  localparam logic [CW-1:0] C_DARK   = CW'(DARK_CYC - 1);
  localparam logic [CW-1:0] C_SETTLE = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] C_SMP    = CW'(N - 1);
  localparam logic [CW-1:0] C_WIN    = CW'(N);

  localparam logic [6:0] DC_IDLE  = 7'd64;
  localparam logic [3:0] PGA_IDLE = 4'd0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AMB     = 3'd1,
    S_IR_SET  = 3'd2,
    S_IR_SMP  = 3'd3,
    S_GAP     = 3'd4,
    S_RED_SET = 3'd5,
    S_RED_SMP = 3'd6
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_stop_pend;
  logic [6:0]      r_dc_ir;
  logic [6:0]      r_dc_red;
  logic [3:0]      r_pga_ir;
  logic [3:0]      r_pga_red;
  logic [AW-1:0]   r_acc;
  logic            r_led_ir;
  logic            r_led_red;
  logic [6:0]      r_dc_comp;
  logic [3:0]      r_pga_gain;
  logic [7:0]      r_sample;
  logic            r_sample_ch;
  logic            r_sample_valid;
  logic            r_busy;
  logic            r_overrun;

  state_t          w_nxt_state;
  logic [CW-1:0]   w_nxt_cnt;
  logic            w_last;
  logic            w_stop_eff;
  logic            w_smp;
  logic            w_first_smp;
  logic [AW-1:0]   w_acc_sum;
  logic [7:0]      w_led_avg;
  logic [7:0]      w_result;
  logic            w_new_res;
  logic            w_new_ch;
  logic            w_enter_amb;
  logic            w_start_frame;
  logic [6:0]      w_nxt_dc;
  logic [3:0]      w_nxt_pga;

  assign w_last     = (r_cnt == '0);
  // A stop seen in the final RED_SMP cycle still ends the frame there.
  assign w_stop_eff = r_stop_pend | stop;

  // -------------------------------------------------------------------------
  // Next-state and duration counter
  // -------------------------------------------------------------------------
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = w_last ? '0 : (r_cnt - CW'(1));
    case (r_state)
      S_IDLE: begin
        w_nxt_cnt = '0;
        if (start && !stop) begin
          w_nxt_state = S_AMB;
          w_nxt_cnt   = C_DARK;
        end
      end
      S_AMB: if (w_last) begin
        w_nxt_state = S_IR_SET;
        w_nxt_cnt   = C_SETTLE;
      end
      S_IR_SET: if (w_last) begin
        w_nxt_state = S_IR_SMP;
        w_nxt_cnt   = C_SMP;
      end
      S_IR_SMP: if (w_last) begin
        w_nxt_state = S_GAP;
        w_nxt_cnt   = C_DARK;
      end
      S_GAP: if (w_last) begin
        w_nxt_state = S_RED_SET;
        w_nxt_cnt   = C_SETTLE;
      end
      S_RED_SET: if (w_last) begin
        w_nxt_state = S_RED_SMP;
        w_nxt_cnt   = C_SMP;
      end
      S_RED_SMP: if (w_last) begin
        if (w_stop_eff) begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_state = S_AMB;
          w_nxt_cnt   = C_DARK;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  assign w_enter_amb   = (w_nxt_state == S_AMB) && (r_state != S_AMB);
  assign w_start_frame = (r_state == S_IDLE) && (w_nxt_state == S_AMB);

  // -------------------------------------------------------------------------
  // LED-phase averaging: the first SMP cycle restarts the sum, so no
  // separate clear is needed between phases.
  // -------------------------------------------------------------------------
  assign w_smp       = (r_state == S_IR_SMP) || (r_state == S_RED_SMP);
  assign w_first_smp = (r_cnt == C_SMP);
  assign w_acc_sum   = (w_first_smp ? {AW{1'b0}} : r_acc) + AW'(adc);
  assign w_led_avg   = 8'(w_acc_sum >> AVG_LOG2);
  assign w_new_res   = w_smp && w_last;
  assign w_new_ch    = (r_state == S_RED_SMP);

`ifdef PPG_AMBIENT_SUB_EN
  logic [AW-1:0] r_amb_acc;
  logic [7:0]    r_amb_avg;
  logic          w_amb_win;
  logic          w_amb_first;
  logic [AW-1:0] w_amb_sum;

  // The ambient window is the tail of AMB, nearest to the IR turn-on.
  assign w_amb_win   = (r_state == S_AMB) && (r_cnt < C_WIN);
  assign w_amb_first = (r_state == S_AMB) && (r_cnt == C_SMP);
  assign w_amb_sum   = (w_amb_first ? {AW{1'b0}} : r_amb_acc) + AW'(adc);
  assign w_result    = (w_led_avg > r_amb_avg) ? (w_led_avg - r_amb_avg) : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_amb_acc <= '0;
      r_amb_avg <= '0;
    end else if (w_amb_win) begin
      r_amb_acc <= w_amb_sum;
      if (w_last) r_amb_avg <= 8'(w_amb_sum >> AVG_LOG2);
    end
  end
`else
  assign w_result = w_led_avg;
`endif

  // -------------------------------------------------------------------------
  // Front-end code for the state being entered. On entry to AMB, the codes
  // are being latched on that same edge, so the inputs are used directly.
  // -------------------------------------------------------------------------
  always_comb begin
    w_nxt_dc  = DC_IDLE;
    w_nxt_pga = PGA_IDLE;
    case (w_nxt_state)
      S_AMB: begin
        w_nxt_dc  = w_enter_amb ? dc_ir  : r_dc_ir;
        w_nxt_pga = w_enter_amb ? pga_ir : r_pga_ir;
      end
      S_IR_SET, S_IR_SMP: begin
        w_nxt_dc  = r_dc_ir;
        w_nxt_pga = r_pga_ir;
      end
      S_RED_SET, S_RED_SMP: begin
        w_nxt_dc  = r_dc_red;
        w_nxt_pga = r_pga_red;
      end
      default: begin
        w_nxt_dc  = DC_IDLE;
        w_nxt_pga = PGA_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Frame FSM with registered outputs. Outputs are computed from the next
  // state, so they change on the same edge as r_state.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_stop_pend    <= 1'b0;
      r_dc_ir        <= '0;
      r_dc_red       <= '0;
      r_pga_ir       <= '0;
      r_pga_red      <= '0;
      r_acc          <= '0;
      r_led_ir       <= 1'b0;
      r_led_red      <= 1'b0;
      r_dc_comp      <= DC_IDLE;
      r_pga_gain     <= PGA_IDLE;
      r_sample       <= '0;
      r_sample_ch    <= 1'b0;
      r_sample_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;

      if ((r_state == S_RED_SMP) && w_last && w_stop_eff)
        r_stop_pend <= 1'b0;
      else if ((r_state != S_IDLE) && stop)
        r_stop_pend <= 1'b1;

      if (w_enter_amb) begin
        r_dc_ir   <= dc_ir;
        r_dc_red  <= dc_red;
        r_pga_ir  <= pga_ir;
        r_pga_red <= pga_red;
      end

      if (w_smp) r_acc <= w_acc_sum;

      r_led_ir   <= (w_nxt_state == S_IR_SET)  || (w_nxt_state == S_IR_SMP);
      r_led_red  <= (w_nxt_state == S_RED_SET) || (w_nxt_state == S_RED_SMP);
      r_dc_comp  <= w_nxt_dc;
      r_pga_gain <= w_nxt_pga;
      r_busy     <= (w_nxt_state != S_IDLE);

      // Result port
      if (w_new_res) begin
        if (!r_sample_valid || sample_ready) begin
          r_sample       <= w_result;
          r_sample_ch    <= w_new_ch;
          r_sample_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_sample_valid && sample_ready) begin
        r_sample_valid <= 1'b0;
      end

      if (w_start_frame) r_overrun <= 1'b0;
    end
  end

  assign led_ir       = r_led_ir;
  assign led_red      = r_led_red;
  assign dc_comp      = r_dc_comp;
  assign pga_gain     = r_pga_gain;
  assign sample       = r_sample;
  assign sample_ch    = r_sample_ch;
  assign sample_valid = r_sample_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_ppg_led_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ppg_led_scheduler
//
// Directed bench for ppg_led_scheduler with default parameters
// (frame = 8 AMB + 16 IR_SET + 4 IR_SMP + 8 GAP + 16 RED_SET + 4 RED_SMP).
// Frame cycle j=0 is the first AMB cycle after start is sampled. Inputs are
// driven and outputs sampled 1 ns after each rising edge. The ambient
// subtraction test is compiled only when PPG_AMBIENT_SUB_EN is defined.
// ---------------------------------------------------------------------------
module tb_ppg_led_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [6:0] dc_ir;
  logic [6:0] dc_red;
  logic [3:0] pga_ir;
  logic [3:0] pga_red;
  logic [7:0] adc;
  logic       led_ir;
  logic       led_red;
  logic [6:0] dc_comp;
  logic [3:0] pga_gain;
  logic [7:0] sample;
  logic       sample_ch;
  logic       sample_valid;
  logic       sample_ready;
  logic       busy;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Result captures: cycle index, value, channel
  int   v_n;
  int   v_j [3];
  int   v_s [3];
  int   v_c [3];
  int   ir_hi;
  int   bad_codes;
  int   both_on;
  int   jj;

  ppg_led_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .dc_ir        (dc_ir),
    .dc_red       (dc_red),
    .pga_ir       (pga_ir),
    .pga_red      (pga_red),
    .adc          (adc),
    .led_ir       (led_ir),
    .led_red      (led_red),
    .dc_comp      (dc_comp),
    .pga_gain     (pga_gain),
    .sample       (sample),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic capture(input int j);
    if (sample_valid && v_n < 3) begin
      v_j[v_n] = j;
      v_s[v_n] = int'(sample);
      v_c[v_n] = int'(sample_ch);
      v_n++;
    end
  endtask

  task automatic clear_capture();
    v_n = 0;
    for (int k = 0; k < 3; k++) begin
      v_j[k] = -1;
      v_s[k] = -1;
      v_c[k] = -1;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    dc_ir = 7'd0; dc_red = 7'd0; pga_ir = 4'd0; pga_red = 4'd0;
    adc = 8'd0; sample_ready = 1'b1;

    // ---------------- Reset values ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_led_ir",   led_ir, 0);
    check("rst_led_red",  led_red, 0);
    check("rst_dc_comp",  dc_comp, 64);
    check("rst_pga",      pga_gain, 0);
    check("rst_sample",   sample, 0);
    check("rst_ch",       sample_ch, 0);
    check("rst_valid",    sample_valid, 0);
    check("rst_busy",     busy, 0);
    check("rst_overrun",  overrun, 0);
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // ---------------- Basic frame ----------------
    dc_ir = 7'd10; pga_ir = 4'd3; dc_red = 7'd20; pga_red = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    clear_capture();
    ir_hi = 0; bad_codes = 0; both_on = 0;
    for (int j = 0; j <= 80; j++) begin
      jj = j % 56;
      adc = (jj >= 24 && jj <= 27) ? 8'd100 : (jj >= 52 && jj <= 55) ? 8'd200 : 8'd0;
      // Mid-frame code changes must not reach the outputs.
      if (j == 10) begin dc_ir = 7'd99; pga_ir = 4'd9; end
      if (j < 56 && led_ir) begin
        ir_hi++;
        if (dc_comp !== 7'd10 || pga_gain !== 4'd3) bad_codes++;
      end
      if (led_ir && led_red) both_on++;
      if (j == 2) begin
        check("amb_dc", dc_comp, 10);
        check("amb_busy", busy, 1);
      end
      if (j == 30) begin
        check("gap_dc", dc_comp, 64);
        check("gap_pga", pga_gain, 0);
      end
      if (j == 40) begin
        check("red_dc", dc_comp, 20);
        check("red_pga", pga_gain, 5);
        check("red_led", led_red, 1);
      end
      capture(j);
      step();
    end
    check("ir_hi_cycles", ir_hi, 20);
    check("ir_code_errs", bad_codes, 0);
    check("leds_overlap", both_on, 0);
    check("basic_n_res", v_n, 2);
    check("basic_ir_j", v_j[0], 28);
    check("basic_ir_val", v_s[0], 100);
    check("basic_ir_ch", v_c[0], 0);
    check("basic_red_j", v_j[1], 56);
    check("basic_red_val", v_s[1], 200);
    check("basic_red_ch", v_c[1], 1);
    check("basic_spacing", v_j[1] - v_j[0], 28);

    // ---------------- Reset mid IR_SMP (j=81) ----------------
    check("pre_rst_led_ir", led_ir, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_led_ir", led_ir, 0);
    check("mid_rst_led_red", led_red, 0);
    check("mid_rst_dc", dc_comp, 64);
    check("mid_rst_pga", pga_gain, 0);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    dc_ir = 7'd10; pga_ir = 4'd3;
    step();
    check("post_rst_valid", sample_valid, 0);

    // ---------------- Averaging + stop during IR_SET ----------------
    start = 1'b1;
    step();
    start = 1'b0;
    clear_capture();
    for (int j = 0; j <= 57; j++) begin
      case (j)
        24: adc = 8'd100;
        25: adc = 8'd101;
        26: adc = 8'd102;
        27: adc = 8'd103;
        52: adc = 8'd7;
        53: adc = 8'd8;
        54: adc = 8'd9;
        55: adc = 8'd10;
        default: adc = 8'd0;
      endcase
      stop = (j == 10);
      if (j == 56) begin
        check("stop_busy", busy, 0);
        check("stop_led_ir", led_ir, 0);
        check("stop_led_red", led_red, 0);
      end
      if (j == 57) check("stop_valid_drop", sample_valid, 0);
      capture(j);
      step();
    end
    stop = 1'b0;
    check("avg_n_res", v_n, 2);
    check("avg_ir_j", v_j[0], 28);
    check("avg_ir_val", v_s[0], 101);
    check("avg_ir_ch", v_c[0], 0);
    check("avg_red_j", v_j[1], 56);
    check("avg_red_trunc", v_s[1], 8);
    check("avg_red_ch", v_c[1], 1);

    // start together with stop in IDLE: no frame
    start = 1'b1; stop = 1'b1;
    step();
    check("startstop_busy1", busy, 0);
    step();
    check("startstop_busy2", busy, 0);
    check("startstop_led", led_ir, 0);
    start = 1'b0; stop = 1'b0;
    step();

    // ---------------- Backpressure ----------------
    sample_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j <= 112; j++) begin
      jj = j % 56;
      adc = (jj >= 24 && jj <= 27) ? 8'd50 : (jj >= 52 && jj <= 55) ? 8'd60 : 8'd0;
      stop = (j == 60);
      if (j == 28) begin
        check("bp_valid", sample_valid, 1);
        check("bp_ir_val", sample, 50);
        check("bp_ir_ch", sample_ch, 0);
      end
      if (j == 55) begin
        check("bp_ovr_before", overrun, 0);
        check("bp_still_valid", sample_valid, 1);
      end
      if (j == 56) begin
        check("bp_held_valid", sample_valid, 1);
        check("bp_held_val", sample, 50);
        check("bp_held_ch", sample_ch, 0);
        check("bp_overrun", overrun, 1);
      end
      if (j == 112) begin
        check("bp_idle_busy", busy, 0);
        check("bp_idle_ovr", overrun, 1);
        check("bp_idle_val", sample, 50);
      end
      step();
    end
    stop = 1'b0;
    sample_ready = 1'b1;
    step();
    check("bp_drain_valid", sample_valid, 0);
    check("bp_drain_ovr", overrun, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("bp_restart_ovr", overrun, 0);
    check("bp_restart_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

`ifdef PPG_AMBIENT_SUB_EN
    // ---------------- Ambient subtraction ----------------
    start = 1'b1;
    step();
    start = 1'b0;
    clear_capture();
    for (int j = 0; j <= 84; j++) begin
      jj = j % 56;
      if (jj <= 3)                    adc = 8'd250;
      else if (jj <= 7)               adc = (j < 56) ? 8'd30 : 8'd120;
      else if (jj >= 24 && jj <= 27)  adc = 8'd100;
      else if (jj >= 52 && jj <= 55)  adc = 8'd100;
      else                            adc = 8'd0;
      stop = (j == 60);
      capture(j);
      step();
    end
    stop = 1'b0;
    check("amb_n_res", v_n, 3);
    check("amb_ir_j", v_j[0], 28);
    check("amb_ir_sub", v_s[0], 70);
    check("amb_red_sub", v_s[1], 70);
    check("amb_ir2_j", v_j[2], 84);
    check("amb_ir_sat", v_s[2], 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
